// File: rtl/obi_mem_be.sv
// obi_mem_be: parametrised OBI slave memory with byte-enable legality, range check and a
// one-entry back-pressurable response stage. Define OBI_MEM_STATS_EN to add request counters.
module obi_mem_be #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_LOG2  = 6,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter logic [31:0] ERR_PATTERN = 32'hDEADBEEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req,
   output logic                    gnt,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    err
`ifdef OBI_MEM_STATS_EN
   ,
   output logic [31:0]             stat_rd,
   output logic [31:0]             stat_wr,
   output logic [31:0]             stat_err
`endif
);

   localparam int unsigned BYTES    = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB = $clog2(BYTES);
   localparam int unsigned IDX_HI   = DEPTH_LOG2 + ADDR_LSB;
   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DATA_WIDTH-1:0] ERR_WORD = {(DATA_WIDTH / 32){ERR_PATTERN}};

   // A legal enable is a naturally aligned run of 2^k ones starting at the address offset.
   function automatic logic be_legal_f(input logic [BYTES-1:0] be_v,
                                       input logic [ADDR_LSB-1:0] off_v);
      logic             ok_v;
      logic [BYTES-1:0] run_v;
      int unsigned      size_v;
      int unsigned      off_u;
      int unsigned      mask_v;
      ok_v  = 1'b0;
      off_u = {{(32 - ADDR_LSB){1'b0}}, off_v};
      for (int unsigned k = 0; k <= ADDR_LSB; k++) begin
         size_v = 32'd1 << k;
         mask_v = ((32'd1 << size_v) - 32'd1) << off_u;
         run_v  = mask_v[BYTES-1:0];
         if (((off_u & (size_v - 32'd1)) == 32'd0) && (be_v == run_v)) begin
            ok_v = 1'b1;
         end else begin
            ok_v = ok_v;
         end
      end
      return ok_v;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  err_r;

   logic                  acc_s;
   logic                  legal_s;
   logic                  in_range_s;
   logic [DEPTH_LOG2-1:0] idx_s;
   logic [DATA_WIDTH-1:0] lane_mask_s;
   logic [DATA_WIDTH-1:0] merged_s;

   genvar g;
   generate
      for (g = 0; g < BYTES; g++) begin : g_lane
         assign lane_mask_s[g*8 +: 8] = {8{be[g]}};
      end
   endgenerate

   assign gnt   = !rvalid_r | rready;
   assign acc_s = req & gnt;
   assign idx_s = addr[IDX_HI-1:ADDR_LSB];

   // Request decode: legality, range and the merged write word.
   always_comb begin
      in_range_s = 1'b0;
      legal_s    = 1'b0;
      merged_s   = {DATA_WIDTH{1'b0}};
      if ((addr >> IDX_HI) == {ADDR_WIDTH{1'b0}}) begin
         in_range_s = 1'b1;
      end else begin
         in_range_s = 1'b0;
      end
      legal_s  = in_range_s & be_legal_f(be, addr[ADDR_LSB-1:0]);
      merged_s = (mem_r[idx_s] & ~lane_mask_s) | (wdata & lane_mask_s);
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (acc_s && legal_s && we) begin
         mem_r[idx_s] <= merged_s;
      end
   end

   // Response stage: loads on accept, otherwise drains when the manager takes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid_r <= 1'b0;
         rdata_r  <= {DATA_WIDTH{1'b0}};
         err_r    <= 1'b0;
      end else if (acc_s) begin
         rvalid_r <= 1'b1;
         if (!legal_s) begin
            err_r   <= 1'b1;
            rdata_r <= ERR_WORD;
         end else if (we) begin
            err_r   <= 1'b0;
            rdata_r <= {DATA_WIDTH{1'b0}};
         end else begin
            err_r   <= 1'b0;
            rdata_r <= mem_r[idx_s] & lane_mask_s;
         end
      end else if (rready) begin
         rvalid_r <= 1'b0;
      end
   end

   assign rvalid = rvalid_r;
   assign rdata  = rdata_r;
   assign err    = err_r;

`ifdef OBI_MEM_STATS_EN
   logic [31:0] stat_rd_r;
   logic [31:0] stat_wr_r;
   logic [31:0] stat_err_r;

   // Accepted-request counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_rd_r  <= 32'd0;
         stat_wr_r  <= 32'd0;
         stat_err_r <= 32'd0;
      end else if (acc_s) begin
         if (!legal_s) begin
            stat_err_r <= stat_err_r + 32'd1;
         end else if (we) begin
            stat_wr_r <= stat_wr_r + 32'd1;
         end else begin
            stat_rd_r <= stat_rd_r + 32'd1;
         end
      end
   end

   assign stat_rd  = stat_rd_r;
   assign stat_wr  = stat_wr_r;
   assign stat_err = stat_err_r;
`endif

endmodule

// File: tb/tb_obi_mem_be.sv
// Scoreboard bench for obi_mem_be: 32-bit and 64-bit instances, stats checked under OBI_MEM_STATS_EN.
module tb_obi_mem_be;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req32, we32, rready32, gnt32, rvalid32, err32;
   logic [31:0] addr32, wdata32, rdata32;
   logic [3:0]  be32;
   logic        req64, we64, rready64, gnt64, rvalid64, err64;
   logic [31:0] addr64;
   logic [63:0] wdata64, rdata64;
   logic [7:0]  be64;
`ifdef OBI_MEM_STATS_EN
   logic [31:0] stat_rd32, stat_wr32, stat_err32;
   logic [31:0] stat_rd64, stat_wr64, stat_err64;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0] q32[$];
   logic [64:0] q64[$];

   typedef struct packed {
      logic [31:0] a; logic w; logic [3:0] b; logic [31:0] d; logic e; logic [31:0] x;
   } tr32_t;
   typedef struct packed {
      logic [31:0] a; logic w; logic [7:0] b; logic [63:0] d; logic e; logic [63:0] x;
   } tr64_t;

   obi_mem_be #(.DATA_WIDTH(32), .DEPTH_LOG2(6), .ADDR_WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .req(req32), .gnt(gnt32), .addr(addr32), .we(we32),
      .be(be32), .wdata(wdata32), .rvalid(rvalid32), .rready(rready32), .rdata(rdata32),
      .err(err32)
`ifdef OBI_MEM_STATS_EN
      , .stat_rd(stat_rd32), .stat_wr(stat_wr32), .stat_err(stat_err32)
`endif
   );

   obi_mem_be #(.DATA_WIDTH(64), .DEPTH_LOG2(6), .ADDR_WIDTH(32)) dut64 (
      .clk(clk), .reset(reset), .req(req64), .gnt(gnt64), .addr(addr64), .we(we64),
      .be(be64), .wdata(wdata64), .rvalid(rvalid64), .rready(rready64), .rdata(rdata64),
      .err(err64)
`ifdef OBI_MEM_STATS_EN
      , .stat_rd(stat_rd64), .stat_wr(stat_wr64), .stat_err(stat_err64)
`endif
   );

   function automatic tr32_t mk32(input logic [31:0] a, input logic w, input logic [3:0] b,
                                  input logic [31:0] d, input logic e, input logic [31:0] x);
      tr32_t t;
      t.a = a; t.w = w; t.b = b; t.d = d; t.e = e; t.x = x;
      return t;
   endfunction

   function automatic tr64_t mk64(input logic [31:0] a, input logic w, input logic [7:0] b,
                                  input logic [63:0] d, input logic e, input logic [63:0] x);
      tr64_t t;
      t.a = a; t.w = w; t.b = b; t.d = d; t.e = e; t.x = x;
      return t;
   endfunction

   task automatic drive32(input tr32_t t);
      req32 = 1'b1; addr32 = t.a; we32 = t.w; be32 = t.b; wdata32 = t.d;
      q32.push_back({t.e, t.x});
   endtask

   task automatic drive64(input tr64_t t);
      req64 = 1'b1; addr64 = t.a; we64 = t.w; be64 = t.b; wdata64 = t.d;
      q64.push_back({t.e, t.x});
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (rvalid32 !== 1'b0 || err32 !== 1'b0 || rdata32 !== 32'h0) begin
         n_errors++;
         $display("FAIL reset32: rvalid=%b err=%b rdata=%h, expected 0 0 00000000", rvalid32, err32, rdata32);
      end
      n_checks++;
      if (rvalid64 !== 1'b0 || err64 !== 1'b0 || rdata64 !== 64'h0) begin
         n_errors++;
         $display("FAIL reset64: rvalid=%b err=%b rdata=%h, expected 0 0 0", rvalid64, err64, rdata64);
      end
      n_checks++;
      if (gnt32 !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_gnt: gnt=%b, expected 1", gnt32);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      tr32_t tab[$];
      logic [32:0] exp;
      tab.push_back(mk32(32'h04, 1'b1, 4'b1111, 32'h11223344, 1'b0, 32'h0));
      tab.push_back(mk32(32'h04, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11223344));
      tab.push_back(mk32(32'h06, 1'b1, 4'b0100, 32'h00AA0000, 1'b0, 32'h0));
      tab.push_back(mk32(32'h04, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11AA3344));
      tab.push_back(mk32(32'h06, 1'b0, 4'b1100, 32'h0, 1'b0, 32'h11AA0000));
      tab.push_back(mk32(32'h07, 1'b0, 4'b1000, 32'h0, 1'b0, 32'h11000000));
      tab.push_back(mk32(32'h05, 1'b0, 4'b0010, 32'h0, 1'b0, 32'h00003300));
      for (int i = 0; i <= tab.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            exp = q32.pop_front();
            if (rvalid32 !== 1'b1 || {err32, rdata32} !== exp) begin
               n_errors++;
               $display("FAIL write_read[%0d]: rvalid=%b err=%b rdata=%h, expected rvalid=1 err=%b rdata=%h",
                        i - 1, rvalid32, err32, rdata32, exp[32], exp[31:0]);
            end
         end
         if (i < tab.size()) drive32(tab[i]);
         else req32 = 1'b0;
      end
   endtask

   task automatic test_illegal();
      tr32_t tab[$];
      logic [32:0] exp;
      tab.push_back(mk32(32'h000, 1'b1, 4'b1111, 32'h55667788, 1'b0, 32'h0));
      tab.push_back(mk32(32'h004, 1'b0, 4'b0101, 32'h0,        1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h004, 1'b1, 4'b0101, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h005, 1'b1, 4'b0011, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h004, 1'b1, 4'b0010, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h004, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h004, 1'b1, 4'b0110, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h100, 1'b1, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF));
      tab.push_back(mk32(32'h000, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h55667788));
      tab.push_back(mk32(32'h004, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h11AA3344));
      for (int i = 0; i <= tab.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            exp = q32.pop_front();
            if (rvalid32 !== 1'b1 || {err32, rdata32} !== exp) begin
               n_errors++;
               $display("FAIL illegal[%0d]: rvalid=%b err=%b rdata=%h, expected rvalid=1 err=%b rdata=%h",
                        i - 1, rvalid32, err32, rdata32, exp[32], exp[31:0]);
            end
         end
         if (i < tab.size()) drive32(tab[i]);
         else req32 = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] exp;
      @(negedge clk);
      drive32(mk32(32'h04, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11AA3344));
      @(negedge clk);
      n_checks++;
      if (rvalid32 !== 1'b1 || {err32, rdata32} !== q32[0]) begin
         n_errors++;
         $display("FAIL bp_first: rvalid=%b err=%b rdata=%h, expected rvalid=1 rdata=%h",
                  rvalid32, err32, rdata32, q32[0][31:0]);
      end
      rready32 = 1'b0;
      drive32(mk32(32'h00, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h55667788));
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         n_checks++;
         if (gnt32 !== 1'b0 || rvalid32 !== 1'b1 || {err32, rdata32} !== q32[0]) begin
            n_errors++;
            $display("FAIL bp_stall[%0d]: gnt=%b rvalid=%b err=%b rdata=%h, expected gnt=0 rvalid=1 err=0 rdata=%h",
                     s, gnt32, rvalid32, err32, rdata32, q32[0][31:0]);
         end
      end
      rready32 = 1'b1;
      void'(q32.pop_front());
      @(negedge clk);
      n_checks++;
      exp = q32.pop_front();
      if (rvalid32 !== 1'b1 || {err32, rdata32} !== exp) begin
         n_errors++;
         $display("FAIL bp_release: rvalid=%b err=%b rdata=%h, expected rvalid=1 rdata=%h",
                  rvalid32, err32, rdata32, exp[31:0]);
      end
      drive32(mk32(32'h06, 1'b0, 4'b1100, 32'h0, 1'b0, 32'h11AA0000));
      @(negedge clk);
      n_checks++;
      exp = q32.pop_front();
      if (rvalid32 !== 1'b1 || {err32, rdata32} !== exp) begin
         n_errors++;
         $display("FAIL bp_b2b: rvalid=%b err=%b rdata=%h, expected rvalid=1 rdata=%h",
                  rvalid32, err32, rdata32, exp[31:0]);
      end
      req32 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rvalid32 !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_drain: rvalid=%b, expected 0", rvalid32);
      end
   endtask

   task automatic test_wide();
      tr64_t tab[$];
      logic [64:0] exp;
      tab.push_back(mk64(32'h08, 1'b1, 8'hFF, 64'h01234567_89ABCDEF, 1'b0, 64'h0));
      tab.push_back(mk64(32'h0C, 1'b1, 8'hF0, 64'hCAFEF00D_00000000, 1'b0, 64'h0));
      tab.push_back(mk64(32'h08, 1'b0, 8'hFF, 64'h0, 1'b0, 64'hCAFEF00D_89ABCDEF));
      tab.push_back(mk64(32'h08, 1'b0, 8'h3C, 64'h0, 1'b1, 64'hDEADBEEF_DEADBEEF));
      tab.push_back(mk64(32'h0C, 1'b0, 8'hF0, 64'h0, 1'b0, 64'hCAFEF00D_00000000));
      tab.push_back(mk64(32'h0A, 1'b0, 8'h0C, 64'h0, 1'b0, 64'h00000000_89AB0000));
      tab.push_back(mk64(32'h08, 1'b0, 8'h0F, 64'h0, 1'b0, 64'h00000000_89ABCDEF));
      tab.push_back(mk64(32'h0C, 1'b1, 8'h0F, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'hDEADBEEF_DEADBEEF));
      tab.push_back(mk64(32'h08, 1'b0, 8'hFF, 64'h0, 1'b0, 64'hCAFEF00D_89ABCDEF));
      for (int i = 0; i <= tab.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            exp = q64.pop_front();
            if (rvalid64 !== 1'b1 || {err64, rdata64} !== exp) begin
               n_errors++;
               $display("FAIL wide[%0d]: rvalid=%b err=%b rdata=%h, expected rvalid=1 err=%b rdata=%h",
                        i - 1, rvalid64, err64, rdata64, exp[64], exp[63:0]);
            end
         end
         if (i < tab.size()) drive64(tab[i]);
         else req64 = 1'b0;
      end
   endtask

`ifdef OBI_MEM_STATS_EN
   task automatic test_stats();
      tr32_t tab[$];
      logic [32:0] exp;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      q32.delete();
      tab.push_back(mk32(32'h04, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11AA3344));
      tab.push_back(mk32(32'h00, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h55667788));
      tab.push_back(mk32(32'h08, 1'b1, 4'b1111, 32'hA5A5A5A5, 1'b0, 32'h0));
      tab.push_back(mk32(32'h04, 1'b0, 4'b0101, 32'h0, 1'b1, 32'hDEADBEEF));
      for (int i = 0; i <= tab.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            exp = q32.pop_front();
            if (rvalid32 !== 1'b1 || {err32, rdata32} !== exp) begin
               n_errors++;
               $display("FAIL stats_resp[%0d]: rvalid=%b err=%b rdata=%h, expected err=%b rdata=%h",
                        i - 1, rvalid32, err32, rdata32, exp[32], exp[31:0]);
            end
         end
         if (i < tab.size()) drive32(tab[i]);
         else req32 = 1'b0;
      end
      n_checks++;
      if (stat_rd32 !== 32'd2 || stat_wr32 !== 32'd1 || stat_err32 !== 32'd1) begin
         n_errors++;
         $display("FAIL stats_count: rd=%0d wr=%0d err=%0d, expected 2 1 1", stat_rd32, stat_wr32, stat_err32);
      end
   endtask
`endif

   task automatic test_reset_mid();
      @(negedge clk);
      rready32 = 1'b0;
      drive32(mk32(32'h04, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11AA3344));
      @(negedge clk);
      req32 = 1'b0;
      n_checks++;
      if (rvalid32 !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_pending: rvalid=%b, expected 1", rvalid32);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (rvalid32 !== 1'b0 || err32 !== 1'b0 || rdata32 !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reset: rvalid=%b err=%b rdata=%h, expected 0 0 00000000", rvalid32, err32, rdata32);
      end
`ifdef OBI_MEM_STATS_EN
      n_checks++;
      if (stat_rd32 !== 32'd0 || stat_wr32 !== 32'd0 || stat_err32 !== 32'd0) begin
         n_errors++;
         $display("FAIL mid_stats: rd=%0d wr=%0d err=%0d, expected 0 0 0", stat_rd32, stat_wr32, stat_err32);
      end
`endif
      q32.delete();
      @(negedge clk);
      reset = 1'b1;
      rready32 = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      req32 = 1'b0; we32 = 1'b0; addr32 = 32'h0; be32 = 4'h0; wdata32 = 32'h0; rready32 = 1'b1;
      req64 = 1'b0; we64 = 1'b0; addr64 = 32'h0; be64 = 8'h0; wdata64 = 64'h0; rready64 = 1'b1;
      #1 reset = 1'b0;
      test_reset();
      test_write_read();
      test_illegal();
      test_backpressure();
      test_wide();
`ifdef OBI_MEM_STATS_EN
      test_stats();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/obi_mem_be.md
Name: obi_mem_be

Overview:
- Parametrised OBI slave memory; successor of the fixed 32-bit, 64-word byte-enable data/instruction memory.
- Generalises data width and depth and checks byte-enable legality per width.
- Adds a req/gnt/rvalid/rready handshake with a registered, back-pressurable one-entry response stage, plus address range checking.
- Sits behind the OBI interconnect as instruction or data memory for the RISC-V core.

Parameters:
- DATA_WIDTH, 32, word width in bits; 32 or 64. BYTES = DATA_WIDTH/8, ADDR_LSB = log2(BYTES).
- DEPTH_LOG2, 6, log2 of word count.
- ADDR_WIDTH, 32, request address width.
- ERR_PATTERN, 32'hDEADBEEF, rdata on error response; replicated to DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid.
- gnt  output  1  request granted (combinational).
- addr  input  ADDR_WIDTH  byte address.
- we  input  1  1 = write, 0 = read.
- be  input  BYTES  byte enables.
- wdata  input  DATA_WIDTH  write data, lane-aligned.
- rvalid  output  1  response valid.
- rready  input  1  manager accepts response.
- rdata  output  DATA_WIDTH  read data, lane-aligned.
- err  output  1  error flag, qualified by rvalid.

Behaviour:
- Reset (reset=0, async): rvalid=0, rdata=0, err=0. Memory array is not reset; contents are undefined until written.
- gnt = !rvalid_q | rready. A request is accepted when req & gnt at a rising edge. At most one request per cycle.
- Legal be: a contiguous, naturally aligned run of 2^k ones (k = 0..ADDR_LSB). The run must start at byte index addr[ADDR_LSB-1:0].
  - 32-bit legal values: 0001, 0010, 0100, 1000, 0011, 1100, 1111, each with matching offset.
  - Illegal: be=0, non-contiguous runs (e.g. 0101), misaligned runs (e.g. 0110), or offset mismatch.
- Range check: addr bits [ADDR_WIDTH-1 : DEPTH_LOG2+ADDR_LSB] must be zero. Otherwise error.
- Word index = addr[DEPTH_LOG2+ADDR_LSB-1 : ADDR_LSB].
- Accepted legal write: enabled bytes of wdata are written to the same lanes at the accept edge; other lanes are unchanged. Response next cycle: rvalid=1, err=0, rdata=0.
- Accepted legal read: response next cycle: rvalid=1, err=0. rdata carries the enabled lanes of the stored word; disabled lanes are 0.
- Accepted illegal request: no array write. Response next cycle: rvalid=1, err=1, rdata=ERR_PATTERN.
- Latency is exactly 1 cycle from accept to rvalid. Throughput is 1 per cycle while rready=1.
- Back-pressure: while rvalid & !rready, rvalid/rdata/err hold stable and gnt=0.
  - Response pops on rvalid & rready. With a new accept in the same cycle, the new response loads next cycle with no bubble.
  - Otherwise rvalid falls to 0. rdata/err keep last values but are don't-care.
- Read-after-write: a write to word W accepted at edge N, followed by a read of W accepted at edge N+1, returns the new data.
- Reset asserted mid-transaction drops any pending response. An in-flight write is either completed or not; no partial-byte guarantee.
- No combinational path from req/addr to rdata.

Optional Feature:
- Macro OBI_MEM_STATS_EN.
- Defined: adds three 32-bit outputs, stat_rd, stat_wr, stat_err. Each counts accepted legal reads, accepted legal writes, and accepted illegal requests respectively.
  - Counters are reset to 0 by reset, wrap at 2^32, and increment at the accept edge.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then DATA_WIDTH=32, write addr=0x04 be=1111 wdata=0x11223344; read addr=0x04 be=1111 -> rvalid one cycle after accept, rdata=0x11223344, err=0.
- Write addr=0x06 be=0100 wdata=0x00AA0000, then read 0x04 be=1111 -> 0x11AA3344. Read addr=0x06 be=1100 -> 0x11AA0000.
- Illegal requests -> err=1, rdata=0xDEADBEEF, memory unchanged on re-read: be=0101; addr=0x05 with be=0011; addr=0x100 with DEPTH_LOG2=6.
- Hold rready=0 for 3 cycles during a pending read -> gnt=0, rvalid/rdata stable. Then rready=1 with req -> back-to-back responses with no bubble.
- DATA_WIDTH=64: write addr=0x0C be=11110000 wdata=0xCAFEF00D_00000000, read addr=0x08 be=FF -> upper half 0xCAFEF00D. be=00111100 -> err=1.
- With OBI_MEM_STATS_EN: 2 reads, 1 write, 1 illegal request -> stat_rd=2, stat_wr=1, stat_err=1; asserting reset mid-stream clears all three to 0 and rvalid to 0.
